// File: rtl/axis_pkt_source.sv
// axis_pkt_source: AXI-Stream byte packet generator with incrementing payload,
// programmable packet length/count, inter-packet gap and tready back-pressure.
`default_nettype none

module axis_pkt_source #(
  parameter int LEN_W      = 13,
  parameter int CNT_W      = 16,
  parameter int GAP_CYCLES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [LEN_W-1:0] pkt_len,
  input  logic [CNT_W-1:0] num_pkts,
  input  logic [7:0]       seed,
  output logic [7:0]       m_tdata,
  output logic             m_tvalid,
  input  logic             m_tready,
  output logic             m_tlast,
  output logic             w_en,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] pkts_sent
);

  localparam int GAP_W = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_GAP  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             last_q, last_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] pkts_q, pkts_d;
  logic [CNT_W-1:0] num_q, num_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] beat_q, beat_d;
  logic [GAP_W-1:0] gap_q, gap_d;

  logic [CNT_W-1:0] pkts_inc;
  logic [LEN_W-1:0] beat_inc;

  assign pkts_inc = pkts_q + CNT_W'(1);
  assign beat_inc = beat_q + LEN_W'(1);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pkts_q  <= '0;
      num_q   <= '0;
      len_q   <= '0;
      beat_q  <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pkts_q  <= pkts_d;
      num_q   <= num_d;
      len_q   <= len_d;
      beat_q  <= beat_d;
      gap_q   <= gap_d;
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    valid_d = valid_q;
    last_d  = last_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    pkts_d  = pkts_q;
    num_d   = num_q;
    len_d   = len_q;
    beat_d  = beat_q;
    gap_d   = gap_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          pkts_d = '0;
          len_d  = pkt_len;
          num_d  = num_pkts;
          beat_d = '0;
          if ((pkt_len != '0) && (num_pkts != '0)) begin
            state_d = S_SEND;
            data_d  = seed + 8'd1;
            valid_d = 1'b1;
            last_d  = (pkt_len == LEN_W'(1));
            busy_d  = 1'b1;
          end else begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end
        end
      end

      S_SEND: begin
        if (valid_q && m_tready) begin
          data_d = data_q + 8'd1;
          if (last_q) begin
            pkts_d = pkts_inc;
            beat_d = '0;
            if (pkts_inc == num_q) begin
              state_d = S_DONE;
              valid_d = 1'b0;
              last_d  = 1'b0;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end else if (GAP_CYCLES > 0) begin
              state_d = S_GAP;
              valid_d = 1'b0;
              last_d  = 1'b0;
              gap_d   = '0;
            end else begin
              // back-to-back: next packet's first beat follows with no bubble
              last_d = (len_q == LEN_W'(1));
            end
          end else begin
            beat_d = beat_inc;
            last_d = (beat_inc == (len_q - LEN_W'(1)));
          end
        end
      end

      S_GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = S_SEND;
          valid_d = 1'b1;
          last_d  = (len_q == LEN_W'(1));
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign m_tdata   = data_q;
  assign m_tvalid  = valid_q;
  assign m_tlast   = last_q;
  assign w_en      = valid_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pkts_sent = pkts_q;

endmodule

`default_nettype wire
